// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state enum, default line settings, and the
// clocks-per-bit helper. Used by both the receive and transmit paths.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
   localparam int unsigned DEF_BAUD_RATE = 9600;
   localparam int unsigned DATA_W        = 8;

   // Frame position of the serial receiver/transmitter
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // System clock cycles per bit period
   function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte delivery bus between the UART receiver (master) and the command logic
// (slave).
//   rx_data    : received byte, valid while rx_valid
//   rx_valid   : byte available, held until accepted
//   rx_ready   : consumer accept (transfer on rx_valid && rx_ready)
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, even-parity mismatch
//   overrun    : one-cycle pulse, good byte dropped while holding reg full
interface uart_byte_rx_if;
   import uart_pkg::*;

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              frame_err;
   logic              parity_err;
   logic              overrun;

   modport master (
      output rx_data, rx_valid, frame_err, parity_err, overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, parity_err, overrun,
      output rx_ready
   );

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for an asynchronous input
// that idles high. All flops reset to 1 so a quiet line never looks like an
// edge coming out of reset.
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset
//   i_async  : asynchronous input
//   o_sync   : synchronized level (registered)
//   o_fall_c : combinational falling-edge strobe (o_sync low, previous high)
module uart_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_fall_c
);

   logic r_ff1;
   logic r_ff2;
   logic r_prev;

   // Metastability chain plus one-cycle history of the synchronized level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ff1  <= 1'b1;
         r_ff2  <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_ff1  <= i_async;
         r_ff2  <= r_ff1;
         r_prev <= r_ff2;
      end
   end

   assign o_sync   = r_ff2;
   assign o_fall_c = ~r_ff2 & r_prev;

endmodule

// File: rtl/uart_byte_rx.sv
// UART receive deframer: turns the asynchronous serial line into validated
// bytes delivered over a valid/ready bus, with framing/parity/overrun pulses.
// Default frame is 8N1; defining UART_RX_PARITY_EN selects 8E1 (even parity).
//   clk_50M   : system clock
//   sys_rst_n : asynchronous active-low reset
//   uart_rx   : serial line, idle high, asynchronous
//   rx_if     : byte delivery bus (master side), see uart_byte_rx_if
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
   parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
   input  logic           clk_50M,
   input  logic           sys_rst_n,
   input  logic           uart_rx,
   uart_byte_rx_if.master rx_if
);

   localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);
   localparam int unsigned BIT_W        = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_CNT_MAX / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   uart_state_t       r_state;
   uart_state_t       w_state_nxt;

   logic [CNT_W-1:0]  r_cnt;
   logic [BIT_W-1:0]  r_bit_idx;
   logic [DATA_W-1:0] r_shift;

   logic              w_rx_sync;
   logic              w_rx_fall;

   logic              w_cnt_clr;
   logic              w_frame_clr;
   logic              w_shift_en;
   logic              w_stop_smp;
   logic              w_par_bad;

   logic              r_pub_pend;
   logic              r_ferr_pend;

   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_frame_err;
   logic              r_overrun;

   uart_sync_edge u_sync (
      .clk      (clk_50M),
      .rst_n    (sys_rst_n),
      .i_async  (uart_rx),
      .o_sync   (w_rx_sync),
      .o_fall_c (w_rx_fall)
   );

   // State register
   always_ff @(posedge clk_50M or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_smp;
`endif

   // Next-state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_frame_clr = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            // Counter held at 0 so START timing begins at the edge
            w_cnt_clr = 1'b1;
            if (w_rx_fall) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (r_cnt == CNT_HALF) begin
               // Line back high at mid start bit: treat as glitch
               if (w_rx_sync) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_clr   = 1'b1;
                  w_frame_clr = 1'b1;
                  w_state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_clr  = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (r_cnt == CNT_FULL) begin
               w_cnt_clr   = 1'b1;
               w_par_smp   = 1'b1;
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is caught
            if (r_cnt == CNT_FULL) begin
               w_cnt_clr   = 1'b1;
               w_stop_smp  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bit-period counter, bit index and LSB-first shift register
   always_ff @(posedge clk_50M or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
         if (w_frame_clr)     r_bit_idx <= '0;
         else if (w_shift_en) r_bit_idx <= r_bit_idx + BIT_W'(1);
         if (w_shift_en) r_shift <= {w_rx_sync, r_shift[DATA_W-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_err;
   logic r_perr_pend;
   logic r_parity_err;

   // Even parity: data bits XOR parity bit must be 0
   always_ff @(posedge clk_50M or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_par_err    <= 1'b0;
         r_perr_pend  <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_frame_clr)    r_par_err <= 1'b0;
         else if (w_par_smp) r_par_err <= ^{r_shift, w_rx_sync};
         r_perr_pend  <= w_stop_smp & w_rx_sync & r_par_err;
         r_parity_err <= r_perr_pend;
      end
   end

   assign w_par_bad        = r_par_err;
   assign rx_if.parity_err = r_parity_err;
`else
   assign w_par_bad        = 1'b0;
   assign rx_if.parity_err = 1'b0;
`endif

   // Stop-sample outcome, acted on one cycle later
   always_ff @(posedge clk_50M or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pub_pend  <= 1'b0;
         r_ferr_pend <= 1'b0;
      end else begin
         r_pub_pend  <= w_stop_smp & w_rx_sync & ~w_par_bad;
         r_ferr_pend <= w_stop_smp & ~w_rx_sync;
      end
   end

   // Holding register and pulse outputs; errors never touch data/valid
   always_ff @(posedge clk_50M or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= r_ferr_pend;
         r_overrun   <= 1'b0;
         if (r_pub_pend) begin
            // Holding reg free now or being emptied this cycle
            if (!r_rx_valid || rx_if.rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun  <= 1'b1;
            end
         end else if (r_rx_valid && rx_if.rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_if.rx_data   = r_rx_data;
   assign rx_if.rx_valid  = r_rx_valid;
   assign rx_if.frame_err = r_frame_err;
   assign rx_if.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;
   import uart_pkg::*;

   localparam int unsigned CLK_FREQ  = 3_200_000;
   localparam int unsigned BAUD_RATE = 100_000;
   localparam int unsigned B         = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned NBITS = 10;
`else
   localparam int unsigned NBITS = 9;
`endif
   // Cycles from the drive edge k (line driven low just after it) to rx_valid rise
   localparam int LAT = 4 + int'(B / 2) + int'(NBITS * B);

   logic clk_50M   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic uart_rx   = 1'b1;
`ifdef UART_RX_PARITY_EN
   logic bad_par   = 1'b0;
`endif

   uart_byte_rx_if rx_if ();

   uart_byte_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk_50M   (clk_50M),
      .sys_rst_n (sys_rst_n),
      .uart_rx   (uart_rx),
      .rx_if     (rx_if.master)
   );

   always #10 clk_50M = ~clk_50M;

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0;
   always @(posedge clk_50M) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   int   rise_cnt = 0, last_rise = 0;
   int   fe_cyc = 0, last_fe = 0;
   int   pe_cyc = 0, last_pe = 0;
   int   ov_cyc = 0, last_ov = 0;
   logic prev_valid = 1'b0;

   // Observe the bus mid-cycle: transfers, valid rises and pulse widths
   always @(negedge clk_50M) begin
      if (rx_if.rx_valid && rx_if.rx_ready) obs_q.push_back(rx_if.rx_data);
      if (rx_if.rx_valid && !prev_valid) begin
         rise_cnt  <= rise_cnt + 1;
         last_rise <= cyc;
      end
      prev_valid <= rx_if.rx_valid;
      if (rx_if.frame_err)  begin fe_cyc <= fe_cyc + 1; last_fe <= cyc; end
      if (rx_if.parity_err) begin pe_cyc <= pe_cyc + 1; last_pe <= cyc; end
      if (rx_if.overrun)    begin ov_cyc <= ov_cyc + 1; last_ov <= cyc; end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   // Drive one frame; k returns the edge index just before the start bit
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic expect_pub, output int k);
      k = cyc;
      if (expect_pub) exp_q.push_back(d);
      uart_rx = 1'b0;
      tick(B);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         tick(B);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^d) ^ bad_par;
      tick(B);
`endif
      uart_rx = stop_bit;
      tick(B);
      uart_rx = 1'b1;
   endtask

   task automatic wait_obs();
      for (int i = 0; i < 64 && obs_q.size() < exp_q.size(); i++) tick(1);
   endtask

   task automatic test_reset();
      sys_rst_n      = 1'b0;
      rx_if.rx_ready = 1'b0;
      uart_rx        = 1'b1;
      tick(3);
      n_checks++;
      if ({rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err, rx_if.overrun} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err, rx_if.overrun});
      end
      n_checks++;
      if (rx_if.rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 00", rx_if.rx_data);
      end
      sys_rst_n = 1'b1;
      tick(5);
      n_checks++;
      if (dut.r_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE);
      end
   endtask

   task automatic test_nominal();
      int k1, k;
      int r0, e0;
      logic [7:0] e, o;
      r0 = rise_cnt;
      e0 = fe_cyc + pe_cyc + ov_cyc;
      rx_if.rx_ready = 1'b1;
      send_frame(8'h00, 1'b1, 1'b1, k1);
      n_checks++;
      if (last_rise - k1 !== LAT) begin
         n_fail++;
         $display("FAIL nominal_latency: got %0d expected %0d", last_rise - k1, LAT);
      end
      send_frame(8'hA5, 1'b1, 1'b1, k);
      send_frame(8'hFF, 1'b1, 1'b1, k);
      tick(4);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL nominal_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL nominal_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (rise_cnt - r0 !== 3) begin
         n_fail++;
         $display("FAIL nominal_valid_pulses: got %0d expected 3", rise_cnt - r0);
      end
      n_checks++;
      if (fe_cyc + pe_cyc + ov_cyc - e0 !== 0) begin
         n_fail++;
         $display("FAIL nominal_errors: got %0d expected 0", fe_cyc + pe_cyc + ov_cyc - e0);
      end
   endtask

   task automatic test_glitch();
      int k, r0, e0;
      logic [7:0] e, o;
      r0 = rise_cnt;
      e0 = fe_cyc + pe_cyc + ov_cyc;
      uart_rx = 1'b0;
      tick(5);
      uart_rx = 1'b1;
      tick(2 * B);
      n_checks++;
      if (rise_cnt - r0 !== 0 || fe_cyc + pe_cyc + ov_cyc - e0 !== 0) begin
         n_fail++;
         $display("FAIL glitch_quiet: got valid=%0d err=%0d expected 0 0",
                  rise_cnt - r0, fe_cyc + pe_cyc + ov_cyc - e0);
      end
      n_checks++;
      if (dut.r_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL glitch_state: got %0d expected %0d", dut.r_state, ST_IDLE);
      end
      send_frame(8'h3C, 1'b1, 1'b1, k);
      tick(4);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL glitch_follow_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL glitch_follow_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_frame_err();
      int k, r0, f0;
      logic [7:0] e, o;
      r0 = rise_cnt;
      f0 = fe_cyc;
      send_frame(8'h55, 1'b0, 1'b0, k);
      tick(4);
      n_checks++;
      if (fe_cyc - f0 !== 1) begin
         n_fail++;
         $display("FAIL frame_err_width: got %0d cycles expected 1", fe_cyc - f0);
      end
      n_checks++;
      if (last_fe - k !== LAT) begin
         n_fail++;
         $display("FAIL frame_err_time: got %0d expected %0d", last_fe - k, LAT);
      end
      n_checks++;
      if (rise_cnt - r0 !== 0 || rx_if.rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err_valid: got rises=%0d valid=%b expected 0 0",
                  rise_cnt - r0, rx_if.rx_valid);
      end
      send_frame(8'h12, 1'b1, 1'b1, k);
      tick(4);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL frame_err_follow_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL frame_err_follow_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_overrun();
      int k1, k2, r0, o0;
      logic [7:0] e, o;
      r0 = rise_cnt;
      o0 = ov_cyc;
      rx_if.rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1, k1);
      send_frame(8'h22, 1'b1, 1'b0, k2);
      tick(4);
      n_checks++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_hold: got valid=%b data=%h expected 1 11",
                  rx_if.rx_valid, rx_if.rx_data);
      end
      n_checks++;
      if (ov_cyc - o0 !== 1) begin
         n_fail++;
         $display("FAIL overrun_width: got %0d cycles expected 1", ov_cyc - o0);
      end
      n_checks++;
      if (last_ov - k2 !== LAT) begin
         n_fail++;
         $display("FAIL overrun_time: got %0d expected %0d", last_ov - k2, LAT);
      end
      rx_if.rx_ready = 1'b1;
      tick(3);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL overrun_release_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL overrun_release_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (rx_if.rx_valid !== 1'b0 || rise_cnt - r0 !== 1) begin
         n_fail++;
         $display("FAIL overrun_after: got valid=%b rises=%0d expected 0 1",
                  rx_if.rx_valid, rise_cnt - r0);
      end
   endtask

   task automatic test_reset_mid();
      int k, r0, e0;
      logic [7:0] d;
      logic [7:0] e, o;
      rx_if.rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b0, k);
      tick(2);
      n_checks++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got valid=%b data=%h expected 1 5a",
                  rx_if.rx_valid, rx_if.rx_data);
      end
      d = 8'hC3;
      uart_rx = 1'b0;
      tick(B);
      for (int i = 0; i < 4; i++) begin
         uart_rx = d[i];
         tick(B);
      end
      uart_rx = d[4];
      tick(B / 2);
      sys_rst_n = 1'b0;
      tick(2);
      n_checks++;
      if ({rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err, rx_if.overrun} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got data=%h flags=%b expected 00 0000", rx_if.rx_data,
                  {rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err, rx_if.overrun});
      end
      r0 = rise_cnt;
      e0 = fe_cyc + pe_cyc + ov_cyc;
      tick(B / 2 - 2);
      for (int i = 5; i < 8; i++) begin
         uart_rx = d[i];
         tick(B);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = ^d;
      tick(B);
`endif
      uart_rx = 1'b1;
      tick(B + 4);
      sys_rst_n = 1'b1;
      tick(2 * B);
      n_checks++;
      if (rise_cnt - r0 !== 0 || fe_cyc + pe_cyc + ov_cyc - e0 !== 0 || rx_if.rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: got rises=%0d err=%0d valid=%b expected 0 0 0",
                  rise_cnt - r0, fe_cyc + pe_cyc + ov_cyc - e0, rx_if.rx_valid);
      end
      rx_if.rx_ready = 1'b1;
      send_frame(8'h7E, 1'b1, 1'b1, k);
      tick(4);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL reset_mid_follow_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_follow_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int k, r0, p0;
      logic [7:0] e, o;
      r0 = rise_cnt;
      p0 = pe_cyc;
      rx_if.rx_ready = 1'b1;
      bad_par = 1'b0;
      send_frame(8'h07, 1'b1, 1'b1, k);
      bad_par = 1'b1;
      send_frame(8'h07, 1'b1, 1'b0, k);
      bad_par = 1'b0;
      tick(4);
      wait_obs();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL parity_good_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL parity_good_data: got %h expected %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (pe_cyc - p0 !== 1) begin
         n_fail++;
         $display("FAIL parity_err_width: got %0d cycles expected 1", pe_cyc - p0);
      end
      n_checks++;
      if (last_pe - k !== LAT) begin
         n_fail++;
         $display("FAIL parity_err_time: got %0d expected %0d", last_pe - k, LAT);
      end
      n_checks++;
      if (rise_cnt - r0 !== 1) begin
         n_fail++;
         $display("FAIL parity_valid_pulses: got %0d expected 1", rise_cnt - r0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

UART receive deframer for `fpga_slave`. It turns the asynchronous `uart_rx` pin into validated bytes, by default 8N1 at 9600 baud from the 50 MHz system clock. Downstream, the command/register logic consumes each byte through a valid/ready handshake. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in baud.
- `BAUD_CNT_MAX`, derived as `CLK_FREQ/BAUD_RATE` (5208): clock cycles per bit.
- `clk_50M`  in  1  system clock, single clock domain.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk_50M`.
- `rx_data`  out  8  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts when `rx_valid` && `rx_ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the holding register was full.

## Operation
- **Synchronizer.** `uart_rx` passes through a 2-FF synchronizer to give `rx_sync`. A falling edge is `rx_sync`=0 while its registered copy is 1.
- **IDLE.** On a falling edge, go to START and clear the bit counter.
- **START.** At counter = `BAUD_CNT_MAX/2 - 1` (2603), sample `rx_sync`.
  - 1: glitch, return to IDLE with nothing reported.
  - 0: clear the counter and go to DATA.
- **DATA.** Sample at counter = `BAUD_CNT_MAX - 1` (mid-bit), LSB first, and shift into an 8-bit register. After bit 7, go to PARITY (macro on) or STOP.
- **PARITY.** Sample at mid-bit. Even parity: the XOR of the 8 data bits and the parity bit must be 0, otherwise latch a pending parity error.
- **STOP.** Sample at mid-bit, then return to IDLE in the next cycle. The block does not wait for the end of the stop bit, so back-to-back frames are caught.
  - Stop = 0: pulse `frame_err`, discard the byte.
  - Stop = 1 with parity error pending: pulse `parity_err`, discard the byte.
  - Stop = 1 with no error: publish the byte.
- **Publish rules.**
  - `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle: load the new byte; `rx_valid` stays 1.
  - `rx_valid`=1 and `rx_ready`=0: pulse `overrun`; the old byte is kept unchanged.
- **Hold and release.** `rx_data` is stable while `rx_valid`=1. `rx_valid` clears on acceptance unless a new byte is published in that same cycle.
- **Error isolation.** Errors never modify `rx_data` or `rx_valid`.
- **Line held low.** If the line stays low after a frame error (break), IDLE waits for a rising edge and then a new falling edge before starting again.

## Timing
- **Reset.** All outputs reset to 0 (`rx_data`=8'h00). State resets to IDLE, counters to 0, and both synchronizer FFs to 1.
- **Reset mid-frame.** Asserting reset during a frame aborts it; nothing is reported.
- **Latency.** Let T0 be the rising edge at which the first sync FF captures 0. State is START after edge T0+2. For 8N1 defaults, `rx_valid` rises at edge T0 + 2 + 2604 + 9×5208 + 1 = T0+49479.
  - With `UART_RX_PARITY_EN`: add 5208.
- **Error pulses.** `frame_err`, `parity_err` and `overrun` assert in the same cycle `rx_valid` would have risen, for exactly 1 cycle.
- **Tolerance.** Mid-bit sampling tolerates ±4% baud mismatch over one frame.
- **Counter width.** The counter is `$clog2(BAUD_CNT_MAX)` bits, 13 at defaults. It wraps only by explicit clear, never by overflow.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1 and the PARITY state exists.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1, there is no PARITY state, and `parity_err` is tied to 0.

## Structure
- **Shared package `uart_pkg`:**
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - default `CLK_FREQ` and `BAUD_RATE`;
  - a `BAUD_CNT_MAX` helper function.
  - The transmit side reuses it.
- **Sub-module `uart_sync_edge`:** the 2-FF synchronizer plus falling-edge detector, with reset value 1. It is instantiated once here and reused by the SPI slave inputs.

## Test plan
All bits are driven for 5208×20 ns.
- **Nominal byte.** After reset release, send 0x00, then 0xA5, then 0xFF back-to-back, with `rx_ready`=1 throughout.
  - Expect 3 `rx_valid` pulses carrying 0x00, 0xA5, 0xFF.
  - The first `rx_valid` rises 49479 cycles after T0.
  - No error pulses.
- **Glitch rejection.** Drive `uart_rx` low for 1000 cycles, then return high.
  - Expect no `rx_valid` and no error pulses; state back in IDLE.
  - A following 0x3C is received correctly.
- **Framing error.** Send 0x55 with the stop bit driven 0.
  - Expect a 1-cycle `frame_err`; `rx_valid` stays 0.
  - The next frame, 0x12, is received correctly.
- **Overrun.** Hold `rx_ready`=0 and send 0x11 then 0x22.
  - Expect `rx_data`=0x11 held, plus a `overrun` pulse at the 0x22 stop sample.
  - Raising `rx_ready` yields 0x11 once, then `rx_valid`=0.
- **Reset mid-frame.** Pull `sys_rst_n` low during bit 4 of 0xC3, then release.
  - Expect all outputs 0 and no byte or error.
  - A following 0x7E is received correctly.
- **Parity (with `UART_RX_PARITY_EN`).** Send 0x07 with parity bit 1 (good), then 0x07 with parity bit 0.
  - Expect the first byte published as 0x07.
  - Expect the second to give a 1-cycle `parity_err` and no `rx_valid`.
